top_module_lock_display: RTL and testbench
==========================================

# top_module_lock_display

Board-level front end that captures eight 6-bit digit settings on a debounced/synchronized `enter_button` press. It drives an 8-digit multiplexed seven-segment display, a 16-bit status LED bank and a packed 16-bit `code` word. It is the top of the design and connects directly to switches, push-button, LEDs and the display.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each display digit stays lit (must be ≥1).
- `DEBOUNCE_CYCLES`, default 1000000: stable cycles required on `enter_button` (used only with the debounce feature).
- `clock`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enter_button`  in  1  asynchronous push-button, active-high.
- `d1`..`d8`  in  6 each  digit settings: [5]=enable, [4]=decimal point, [3:0]=hex value.
- `led`  out  16  [15:8]=latched enable mask (bit 8+i = d(i+1)[5]), [7:0]=enter-press counter.
- `an`  out  8  digit anodes, active-low, exactly one low at a time.
- `seg`  out  8  segments, active-low, {dp,g,f,e,d,c,b,a}.
- `code`  out  16  latched {d4[3:0],d3[3:0],d2[3:0],d1[3:0]}.

## Operation
- Input path: `enter_button` → 2-FF synchronizer → (optional debounce) → rising-edge detector giving one-cycle `enter_pulse`.
- On `enter_pulse`:
  - latch all eight `dN` into digit registers;
  - `code` updates from the newly latched values;
  - `led[15:8]` updates to the new enable mask;
  - `led[7:0]` increments by 1, wrapping 255→0.
- Holding the button produces exactly one pulse; release produces none.
- `dN` changes without a press have no effect on any output.
- Display scan:
  - a prescaler counts 0..REFRESH_DIV-1; at terminal count the 3-bit digit index increments, wrapping 7→0;
  - index i drives `an` = ~(1<<i) and shows latched digit i+1 (`an[0]`↔d1 … `an[7]`↔d8).
- Segment decode for the selected digit:
  - enable=0: `seg` = 8'hFF (blank; anode still driven);
  - enable=1: `seg[6:0]` = active-low hex glyph of [3:0]; `seg[7]` = ~dp.
- Hex glyphs, active-low, as 7-bit g..a values:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78;
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- `an` and `seg` are registered, so they always change together.

## Timing
- Reset (`reset`=0, asynchronous) clears:
  - digit registers, prescaler, index, synchronizer, debounce state and counter → 0;
  - outputs: `an`=8'hFE, `seg`=8'hFF, `led`=16'h0000, `code`=16'h0000.
- Reset mid-press: after release of reset, a button still held does not generate a pulse until it is released and pressed again.
  - The edge detector's previous-value register resets to 1 so an already-high input is not treated as a new edge.
- Enter latency without debounce: outputs `code`/`led` change on the 3rd rising clock edge after `enter_button` goes high (setup met).
- With debounce: latency = 3 + DEBOUNCE_CYCLES edges.
- Display: the index advances every REFRESH_DIV cycles.
  - `an`/`seg` reflect the new index one cycle after the prescaler terminal count.
  - Full frame = 8×REFRESH_DIV cycles.
- A press occurring at the same edge as a scan step:
  - both take effect;
  - the newly displayed digit shows the new latched data from the following cycle.

## Configuration
- `TOP_MODULE_DEBOUNCE_EN` defined:
  - a counter requires the synchronized button level to be stable for DEBOUNCE_CYCLES consecutive cycles before the debounced level changes;
  - glitches shorter than that are ignored.
- Undefined: debounced level = synchronizer output; `DEBOUNCE_CYCLES` unused.

## Test plan
- Reset: hold `reset`=0 → `an`=FE, `seg`=FF, `led`=0000, `code`=0000; release → same until first press.
- Latch:
  - stimulus: d1=6'h21, d2=6'h22, d3=6'h23, d4=6'h24, d5..d8=0, then one press;
  - required after 3 edges: `code`=16'h4321, `led`=16'h0F01.
  - Then change d1 without pressing → `code` unchanged.
- Scan (REFRESH_DIV=4):
  - with d1=6'h30 latched → while `an`=FE, `seg`=8'h40 (dp on, glyph 0);
  - `an` cycles FE,FD,…,7F every 4 cycles;
  - disabled digits show `seg`=FF.
- Hold/wrap:
  - holding button 50 cycles → counter +1 only;
  - 256 presses → `led[7:0]` returns to 00.
- Reset mid-operation:
  - assert `reset` while button held and digits latched → all outputs return to reset values immediately;
  - no pulse after release until a new press.
- With `TOP_MODULE_DEBOUNCE_EN`, DEBOUNCE_CYCLES=8:
  - a 5-cycle button glitch → no latch;
  - a 20-cycle press → exactly one latch at edge 11.

Source files
------------

// File: rtl/top_module_lock_display.sv
// Digit-latch front end: a synchronized enter press captures eight digit settings,
// which are scanned onto a multiplexed 7-segment display. Optional debounce: TOP_MODULE_DEBOUNCE_EN.
module top_module_lock_display #(
   parameter int REFRESH_DIV     = 100000,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enter_button,
   input  logic [5:0]  d1,
   input  logic [5:0]  d2,
   input  logic [5:0]  d3,
   input  logic [5:0]  d4,
   input  logic [5:0]  d5,
   input  logic [5:0]  d6,
   input  logic [5:0]  d7,
   input  logic [5:0]  d8,
   output logic [15:0] led,
   output logic [7:0]  an,
   output logic [7:0]  seg,
   output logic [15:0] code
);

   logic [1:0] r_sync;
   logic [1:0] r_warm;
   logic       r_armed;
   logic       r_prev;
   logic       w_level;
   logic       w_pulse;
   logic [5:0] r_dig [8];
   logic [5:0] w_din [8];
   logic [7:0] r_cnt;
   logic [31:0] r_pre;
   logic [2:0] r_idx;
   logic [7:0] r_an;
   logic [7:0] r_seg;
   logic [5:0] w_sel;
   logic [6:0] w_glyph;
   logic [7:0] w_mask;

   assign w_din = '{d1, d2, d3, d4, d5, d6, d7, d8};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_sync  <= '0;
         r_warm  <= '0;
         r_armed <= 1'b0;
         r_prev  <= 1'b1;
      end else begin
         r_sync <= {r_sync[0], enter_button};
         r_warm <= {r_warm[0], 1'b1};
         // A press still held through reset must be released before it can count.
         if (r_warm[1] && !r_sync[1])
            r_armed <= 1'b1;
         r_prev <= w_level;
      end
   end

`ifdef TOP_MODULE_DEBOUNCE_EN
   logic        r_db_level;
   logic [31:0] r_db_cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_db_level <= 1'b0;
         r_db_cnt   <= '0;
      end else if (r_sync[1] != r_db_level) begin
         if (r_db_cnt == 32'(DEBOUNCE_CYCLES - 1)) begin
            r_db_level <= r_sync[1];
            r_db_cnt   <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + 32'd1;
         end
      end else begin
         r_db_cnt <= '0;
      end
   end

   assign w_level = r_db_level;
`else
   // DEBOUNCE_CYCLES has no effect without debounce; the term is constant-true.
   assign w_level = r_sync[1] & (DEBOUNCE_CYCLES >= 0);
`endif

   assign w_pulse = w_level & ~r_prev & r_armed;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < 8; i++)
            r_dig[i] <= '0;
         r_cnt <= '0;
      end else if (w_pulse) begin
         for (int unsigned i = 0; i < 8; i++)
            r_dig[i] <= w_din[i];
         r_cnt <= r_cnt + 8'd1;
      end
   end

   assign w_sel = r_dig[r_idx];

   always_comb begin
      w_glyph = 7'h7F;
      case (w_sel[3:0])
         4'h0: w_glyph = 7'h40;
         4'h1: w_glyph = 7'h79;
         4'h2: w_glyph = 7'h24;
         4'h3: w_glyph = 7'h30;
         4'h4: w_glyph = 7'h19;
         4'h5: w_glyph = 7'h12;
         4'h6: w_glyph = 7'h02;
         4'h7: w_glyph = 7'h78;
         4'h8: w_glyph = 7'h00;
         4'h9: w_glyph = 7'h10;
         4'hA: w_glyph = 7'h08;
         4'hB: w_glyph = 7'h03;
         4'hC: w_glyph = 7'h46;
         4'hD: w_glyph = 7'h21;
         4'hE: w_glyph = 7'h06;
         default: w_glyph = 7'h0E;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_pre <= '0;
         r_idx <= '0;
         r_an  <= 8'hFE;
         r_seg <= 8'hFF;
      end else begin
         if (r_pre == 32'(REFRESH_DIV - 1)) begin
            r_pre <= '0;
            r_idx <= r_idx + 3'd1;
         end else begin
            r_pre <= r_pre + 32'd1;
         end
         r_an  <= ~(8'h01 << r_idx);
         r_seg <= w_sel[5] ? {~w_sel[4], w_glyph} : 8'hFF;
      end
   end

   always_comb begin
      w_mask = '0;
      for (int unsigned i = 0; i < 8; i++)
         w_mask[i] = r_dig[i][5];
   end

   assign an   = r_an;
   assign seg  = r_seg;
   assign led  = {w_mask, r_cnt};
   assign code = {r_dig[3][3:0], r_dig[2][3:0], r_dig[1][3:0], r_dig[0][3:0]};

endmodule

// File: tb/tb_top_module_lock_display.sv
// Bench for top_module_lock_display: directed and random presses checked against a
// shadow of the latched digits, plus a time-based model of the display scan.
module tb_top_module_lock_display;

   localparam int REF = 4;
   localparam int DB  = 8;
`ifdef TOP_MODULE_DEBOUNCE_EN
   localparam int LAT = 3 + DB;
`else
   localparam int LAT = 3;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        enter_button = 1'b0;
   logic [5:0]  tb_d [8];
   logic [15:0] led;
   logic [7:0]  an;
   logic [7:0]  seg;
   logic [15:0] code;

   int n_checks = 0;
   int n_err    = 0;

   logic [5:0]  m_d [8];
   logic [7:0]  m_cnt;
   int unsigned edges;

   logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   top_module_lock_display #(.REFRESH_DIV(REF), .DEBOUNCE_CYCLES(DB)) dut (
      .clock(clock), .reset(reset), .enter_button(enter_button),
      .d1(tb_d[0]), .d2(tb_d[1]), .d3(tb_d[2]), .d4(tb_d[3]),
      .d5(tb_d[4]), .d6(tb_d[5]), .d7(tb_d[6]), .d8(tb_d[7]),
      .led(led), .an(an), .seg(seg), .code(code)
   );

   always #5 clock = ~clock;

   // Edges since reset release; the scan position is a pure function of this.
   always @(posedge clock or negedge reset) begin
      if (!reset) edges <= 0;
      else        edges <= edges + 1;
   end

   function automatic logic [15:0] exp_code();
      return {m_d[3][3:0], m_d[2][3:0], m_d[1][3:0], m_d[0][3:0]};
   endfunction

   function automatic logic [15:0] exp_led();
      logic [7:0] mask;
      for (int i = 0; i < 8; i++) mask[i] = m_d[i][5];
      return {mask, m_cnt};
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_d[i] = '0;
      m_cnt = '0;
   endtask

   task automatic check_state(input string tag);
      check({tag, ".code"}, code, exp_code());
      check({tag, ".led"},  led,  exp_led());
   endtask

   task automatic press(input int hold);
      @(negedge clock);
      enter_button = 1'b1;
      repeat (LAT - 1) @(negedge clock);
      check_state("press_early");
      @(negedge clock);
      for (int i = 0; i < 8; i++) m_d[i] = tb_d[i];
      m_cnt = m_cnt + 8'd1;
      check_state("press_latch");
      repeat (hold) @(negedge clock);
      enter_button = 1'b0;
      repeat (LAT + 2) @(negedge clock);
   endtask

   task automatic scan_window(input int n);
      int unsigned idx;
      logic [7:0] e_an, e_seg;
      repeat (n) begin
         @(negedge clock);
         idx   = (edges == 0) ? 0 : ((edges - 1) / REF) % 8;
         e_an  = ~(8'h01 << idx);
         e_seg = m_d[idx][5] ? {~m_d[idx][4], GLYPH[m_d[idx][3:0]]} : 8'hFF;
         check("scan.an",  {8'h00, an},  {8'h00, e_an});
         check("scan.seg", {8'h00, seg}, {8'h00, e_seg});
      end
   endtask

   initial begin
      logic [7:0] cnt_before;
      for (int i = 0; i < 8; i++) tb_d[i] = '0;
      model_reset();

      // Reset held, then released with no press
      repeat (3) @(negedge clock);
      check("rst.an",  {8'h00, an},  16'h00FE);
      check("rst.seg", {8'h00, seg}, 16'h00FF);
      check_state("rst");
      reset = 1'b1;
      repeat (5) @(negedge clock);
      check_state("post_rst");
      check("post_rst.seg", {8'h00, seg}, 16'h00FF);

      // Directed latch
      tb_d[0] = 6'h21; tb_d[1] = 6'h22; tb_d[2] = 6'h23; tb_d[3] = 6'h24;
      press(2);
      check("latch.code_const", code, 16'h4321);
      check("latch.led_const",  led,  16'h0F01);
      tb_d[0] = 6'h3A;
      repeat (10) @(negedge clock);
      check("no_press.code", code, 16'h4321);

      // Scan with mixed enable/dp digits
      tb_d[0] = 6'h30; tb_d[1] = 6'h25; tb_d[2] = 6'h0C; tb_d[3] = 6'h3F;
      tb_d[4] = 6'h2B; tb_d[5] = 6'h00; tb_d[6] = 6'h38; tb_d[7] = 6'h1E;
      press(3);
      scan_window(8 * REF + 6);

      // Long hold counts once
      cnt_before = m_cnt;
      press(50);
      check("hold.cnt", {8'h00, led[7:0]}, {8'h00, cnt_before + 8'd1});

`ifdef TOP_MODULE_DEBOUNCE_EN
      // Short glitch is filtered
      tb_d[0] = 6'h3E;
      @(negedge clock); enter_button = 1'b1;
      repeat (5) @(negedge clock); enter_button = 1'b0;
      repeat (20) @(negedge clock);
      check_state("glitch");
      press(20);
`endif

      // Random digits and hold times
      for (int k = 0; k < 12; k++) begin
         for (int i = 0; i < 8; i++) tb_d[i] = 6'($urandom);
         press(int'($urandom_range(1, 6)));
      end
      scan_window(8 * REF + 3);

      // Counter wrap
      cnt_before = m_cnt;
      for (int k = 0; k < 256; k++) begin
         tb_d[0] = 6'($urandom);
         press(1);
      end
      check("wrap.cnt", {8'h00, led[7:0]}, {8'h00, cnt_before});

      // Reset while the button is held
      for (int i = 0; i < 8; i++) tb_d[i] = 6'($urandom) | 6'h20;
      @(negedge clock); enter_button = 1'b1;
      repeat (LAT + 2) @(negedge clock);
      #2 reset = 1'b0;
      #1;
      model_reset();
      check("midrst.an",  {8'h00, an},  16'h00FE);
      check("midrst.seg", {8'h00, seg}, 16'h00FF);
      check_state("midrst");
      @(negedge clock); reset = 1'b1;
      repeat (LAT + 20) @(negedge clock);
      check_state("held_after_rst");
      enter_button = 1'b0;
      repeat (LAT + 3) @(negedge clock);
      check_state("release_after_rst");
      press(2);
      check("repress.cnt", {8'h00, led[7:0]}, 16'h0001);
      scan_window(8 * REF);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
